// File: rtl/svi_force_ctrl.sv
// Force/release initiator for an N-entry SVI array: applies force controls per command,
// waits a settle time, then returns the resolved array value for the target element.
module svi_force_ctrl #(
  parameter int N = 8,
  parameter int W = 1,
  parameter int SETTLE = 2,
  localparam int IDXW = (N > 1) ? $clog2(N) : 1,
  localparam int CNTW = $clog2(N + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic [1:0]      i_cmd_op,
  input  logic [IDXW-1:0] i_cmd_idx,
  input  logic [W-1:0]    i_cmd_value,
  output logic [N-1:0]    o_force,
  output logic [N*W-1:0]  o_force_value,
  input  logic [N*W-1:0]  i_obs,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [W-1:0]    o_rsp_value,
  output logic            o_rsp_err,
  output logic [CNTW-1:0] o_active_cnt
);

  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [1:0] OP_FORCE = 2'b01;
  localparam logic [1:0] OP_RELEASE = 2'b10;
  localparam logic [1:0] OP_RELEASE_ALL = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_SETTLE, S_RESP} state_t;

  state_t          state;
  logic            rdy_q;
  logic            err_q;
  logic [1:0]      op_q;
  logic [IDXW-1:0] idx_q;
  logic [W-1:0]    val_q;
  logic [SW-1:0]   cnt;
  logic            idx_oor;
  logic [N-1:0]    force_nxt;
  logic [N*W-1:0]  fval_nxt;
  logic [CNTW-1:0] pop_nxt;

  // rdy_q keeps ready low through reset and for the cycle the reset is being released
  assign o_cmd_ready = (state == S_IDLE) && rdy_q;
  assign o_rsp_valid = (state == S_RESP);
  assign idx_oor = (32'(i_cmd_idx) >= 32'(N));

  always_comb begin
    force_nxt = o_force;
    fval_nxt = o_force_value;
    if (!err_q) begin
      case (op_q)
        OP_FORCE: begin
          force_nxt[idx_q] = 1'b1;
          fval_nxt[idx_q*W +: W] = val_q;
        end
        OP_RELEASE: force_nxt[idx_q] = 1'b0;
        OP_RELEASE_ALL: force_nxt = '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    pop_nxt = '0;
    for (int k = 0; k < N; k++) pop_nxt = pop_nxt + CNTW'(force_nxt[k]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      rdy_q <= 1'b0;
      err_q <= 1'b0;
      op_q <= '0;
      idx_q <= '0;
      val_q <= '0;
      cnt <= '0;
      o_force <= '0;
      o_force_value <= '0;
      o_active_cnt <= '0;
      o_rsp_value <= '0;
      o_rsp_err <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (rdy_q && i_cmd_valid) begin
            op_q <= i_cmd_op;
            idx_q <= i_cmd_idx;
            val_q <= i_cmd_value;
            err_q <= idx_oor && (i_cmd_op != OP_RELEASE_ALL);
            state <= S_APPLY;
          end
        end
        S_APPLY: begin
          if (err_q) begin
            // bad index: report without touching the array controls
            o_rsp_err <= 1'b1;
            o_rsp_value <= '0;
            state <= S_RESP;
          end else begin
            o_force <= force_nxt;
            o_force_value <= fval_nxt;
            o_active_cnt <= pop_nxt;
            cnt <= SW'(SETTLE);
            state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt == '0) begin
            o_rsp_err <= 1'b0;
            o_rsp_value <= (op_q == OP_RELEASE_ALL) ? '0 : i_obs[idx_q*W +: W];
            state <= S_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_svi_force_ctrl.sv
// Bench for svi_force_ctrl: one N=8/SETTLE=2 instance and one N=6/SETTLE=0 instance,
// each looped back through a behavioural force/value mux.
module tb_svi_force_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       va, ra, vala;
  logic [1:0] opa;
  logic [2:0] idxa;
  logic       rdy_a, rspv_a, err_a;
  logic [0:0] rv_a;
  logic [7:0] force_a, fval_a, obs_a, base_a, noise_a;
  logic [3:0] cnt_a;

  logic       vb, rb, valb;
  logic [1:0] opb;
  logic [2:0] idxb;
  logic       rdy_b, rspv_b, err_b;
  logic [0:0] rv_b;
  logic [5:0] force_b, fval_b, obs_b;
  logic [2:0] cnt_b;

  assign obs_a = ((force_a & fval_a) | (~force_a & base_a)) ^ noise_a;
  assign obs_b = force_b & fval_b;

  svi_force_ctrl #(.N(8), .W(1), .SETTLE(2)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(va), .o_cmd_ready(rdy_a), .i_cmd_op(opa),
    .i_cmd_idx(idxa), .i_cmd_value(vala), .o_force(force_a), .o_force_value(fval_a),
    .i_obs(obs_a), .o_rsp_valid(rspv_a), .i_rsp_ready(ra), .o_rsp_value(rv_a),
    .o_rsp_err(err_a), .o_active_cnt(cnt_a)
  );

  svi_force_ctrl #(.N(6), .W(1), .SETTLE(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(vb), .o_cmd_ready(rdy_b), .i_cmd_op(opb),
    .i_cmd_idx(idxb), .i_cmd_value(valb), .o_force(force_b), .o_force_value(fval_b),
    .i_obs(obs_b), .o_rsp_valid(rspv_b), .i_rsp_ready(rb), .o_rsp_value(rv_b),
    .o_rsp_err(err_b), .o_active_cnt(cnt_b)
  );

  int checks = 0;
  int failures = 0;

  // reference state: which elements are forced and to what value
  logic [7:0] m_force, m_val;
  logic [5:0] mb_force, mb_val;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input bit b, input logic [1:0] op, input logic [2:0] idx, input logic v);
    int n = 0;
    while (!(b ? rdy_b : rdy_a) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (b) begin vb = 1'b1; opb = op; idxb = idx; valb = v; end
    else begin va = 1'b1; opa = op; idxa = idx; vala = v; end
    @(posedge clk); #1;
    va = 1'b0; vb = 1'b0;
  endtask

  // counts edges after the accept edge until a response is visible
  task automatic wait_rsp(input bit b, output int lat, output logic [7:0] f1);
    lat = 0;
    f1 = '0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) f1 = b ? {2'b00, force_b} : force_a;
    end while (!(b ? rspv_b : rspv_a) && lat < 40);
  endtask

  task automatic ack(input bit b);
    if (b) rb = 1'b1; else ra = 1'b1;
    @(posedge clk); #1;
    ra = 1'b0; rb = 1'b0;
  endtask

  task automatic model_a(input logic [1:0] op, input logic [2:0] idx, input logic v,
                         output logic exp_rv);
    case (op)
      2'd1: begin m_force[idx] = 1'b1; m_val[idx] = v; end
      2'd2: m_force[idx] = 1'b0;
      2'd3: m_force = '0;
      default: ;
    endcase
    exp_rv = (op == 2'd3) ? 1'b0 : (m_force[idx] ? m_val[idx] : base_a[idx]);
  endtask

  task automatic do_a(input string tag, input logic [1:0] op, input logic [2:0] idx, input logic v);
    int lat;
    logic [7:0] f1;
    logic erv;
    send(0, op, idx, v);
    wait_rsp(0, lat, f1);
    model_a(op, idx, v, erv);
    check({tag, "_rsp"}, {8'(lat), 7'b0, rv_a, 7'b0, err_a}, {8'd4, 7'b0, erv, 8'h00});
    check({tag, "_e1"}, f1, m_force);
    check({tag, "_st"}, {force_a, fval_a, cnt_a}, {m_force, m_val, 4'($countones(m_force))});
    ack(0);
  endtask

  task automatic do_b(input string tag, input logic [1:0] op, input logic [2:0] idx, input logic v);
    int lat;
    logic [7:0] f1;
    logic erv, eerr;
    int elat;
    send(1, op, idx, v);
    wait_rsp(1, lat, f1);
    eerr = (idx > 3'd5) && (op != 2'd3);
    erv = 1'b0;
    elat = eerr ? 1 : 2;
    if (!eerr) begin
      case (op)
        2'd1: begin mb_force[idx] = 1'b1; mb_val[idx] = v; end
        2'd2: mb_force[idx] = 1'b0;
        2'd3: mb_force = '0;
        default: ;
      endcase
      erv = (op == 2'd3) ? 1'b0 : (mb_force[idx] & mb_val[idx]);
    end
    check({tag, "_rsp"}, {8'(lat), 7'b0, rv_b, 7'b0, err_b}, {8'(elat), 7'b0, erv, 7'b0, eerr});
    check({tag, "_st"}, {2'b00, force_b, fval_b, cnt_b}, {2'b00, mb_force, mb_val, 3'($countones(mb_force))});
    ack(1);
  endtask

  initial begin
    int lat, bad;
    logic [7:0] f1;
    logic erv, hold_rv, hold_err, seen;

    rst = 1'b1;
    va = 1'b0; ra = 1'b0; opa = 2'd1; idxa = 3'd0; vala = 1'b1;
    vb = 1'b0; rb = 1'b0; opb = 2'd1; idxb = 3'd0; valb = 1'b1;
    base_a = '0; noise_a = '0;
    m_force = '0; m_val = '0; mb_force = '0; mb_val = '0;

    repeat (3) begin
      va = 1'($urandom); vb = 1'($urandom); idxa = 3'($urandom); idxb = 3'($urandom_range(0, 5));
      @(posedge clk); #1;
      check("reset_a", {rdy_a, force_a, fval_a, rspv_a, rv_a, err_a, cnt_a}, '0);
      check("reset_b", {rdy_b, force_b, fval_b, rspv_b, rv_b, err_b, cnt_b}, '0);
    end
    rst = 1'b0; va = 1'b0; vb = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", {rdy_a, rdy_b, rspv_a, force_a, rspv_b, force_b}, {2'b11, 16'h0});

    do_a("force3", 2'd1, 3'd3, 1'b1);
    check("force3_const", {force_a, cnt_a}, {8'h08, 4'd1});
    do_a("read3", 2'd0, 3'd3, 1'b0);
    do_a("read2", 2'd0, 3'd2, 1'b0);

    do_a("rall0", 2'd3, 3'd0, 1'b0);
    do_a("force0", 2'd1, 3'd0, 1'b1);
    do_a("force5", 2'd1, 3'd5, 1'b1);
    do_a("force7", 2'd1, 3'd7, 1'b1);
    check("three_forced", {force_a, cnt_a}, {8'hA1, 4'd3});
    do_a("rel5", 2'd2, 3'd5, 1'b0);
    check("rel5_const", {force_a, cnt_a, fval_a[5]}, {8'h81, 4'd2, 1'b1});
    do_a("rall", 2'd3, 3'd4, 1'b0);
    check("rall_const", {force_a, cnt_a}, {8'h00, 4'd0});
    do_a("rel5_again", 2'd2, 3'd5, 1'b0);

    for (int i = 0; i < 40; i++) begin
      base_a = 8'($urandom);
      do_a("rand", 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom));
    end

    // response held off while the observed array changes underneath
    base_a = 8'($urandom);
    send(0, 2'd0, 3'd6, 1'b0);
    wait_rsp(0, lat, f1);
    model_a(2'd0, 3'd6, 1'b0, erv);
    check("bp_rsp", {8'(lat), 7'b0, rv_a, 7'b0, err_a}, {8'd4, 7'b0, erv, 8'h00});
    hold_rv = rv_a; hold_err = err_a; bad = 0;
    repeat (10) begin
      noise_a = 8'($urandom);
      @(posedge clk); #1;
      if ({rspv_a, rdy_a, rv_a, err_a} !== {1'b1, 1'b0, hold_rv, hold_err}) bad++;
    end
    check("bp_hold", 32'(bad), 64'd0);
    noise_a = '0;
    ra = 1'b1; va = 1'b1; opa = 2'd1; idxa = 3'd2; vala = 1'b1;
    @(posedge clk); #1;
    ra = 1'b0;
    check("bp_no_same_cycle", {rspv_a, rdy_a, force_a}, {1'b0, 1'b1, m_force});
    @(posedge clk); #1;
    va = 1'b0;
    wait_rsp(0, lat, f1);
    model_a(2'd1, 3'd2, 1'b1, erv);
    check("bp_next_rsp", {8'(lat), 7'b0, rv_a, f1}, {8'd4, 7'b0, erv, m_force});
    ack(0);

    // reset while a FORCE is settling
    do_a("pre_rst_rall", 2'd3, 3'd0, 1'b0);
    send(0, 2'd1, 3'd1, 1'b1);
    @(posedge clk); #1;
    check("mid_force_e1", force_a, 8'h02);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_force = '0; m_val = '0;
    check("mid_rst_clear", {force_a, fval_a, cnt_a, rspv_a}, '0);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | rspv_a;
    end
    check("mid_rst_no_rsp", seen, 1'b0);
    base_a = '0;
    do_a("post_rst", 2'd0, 3'd1, 1'b0);

    // N=6, SETTLE=0 instance
    do_b("b_oor7", 2'd1, 3'd7, 1'b1);
    check("b_oor_unchanged", force_b, 6'h00);
    do_b("b_force4", 2'd1, 3'd4, 1'b1);
    check("b_force4_const", {force_b, cnt_b}, {6'h10, 3'd1});
    do_b("b_read4", 2'd0, 3'd4, 1'b0);
    do_b("b_oor6", 2'd0, 3'd6, 1'b0);
    do_b("b_rel_oor", 2'd2, 3'd6, 1'b0);
    do_b("b_rall7", 2'd3, 3'd7, 1'b0);
    for (int i = 0; i < 12; i++)
      do_b("b_rand", 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
